// File: rtl/data_bus_responder_if.sv
// Core-to-responder data SRAM bus.
//   data_sram_en    : access strobe
//   data_sram_wen   : byte write enables, 0 means read
//   data_sram_addr  : byte address
//   data_sram_wdata : write data, lanes already aligned
//   data_sram_rdata : read data, valid one cycle after the read
interface data_bus_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_bus_responder.sv
// Data SRAM responder: word RAM with byte enables plus a small MMIO block
// (LED, switches, scratch, free-running timer, compare with level interrupt).
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : data_sram_* slave port, registered read data (1-cycle latency)
//   switch_in  : board switches, sampled on read
//   led_out    : LED register
//   timer_irq  : level interrupt, set on TIMER==COMPARE, cleared by COMPARE write
module data_bus_responder #(
  parameter int unsigned RAM_AW  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_responder_if.slave  bus,
  input  logic [15:0]          switch_in,
  output logic [15:0]          led_out,
  output logic                 timer_irq
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_SCRATCH = 16'hF008;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_COMPARE = 16'hE004;

  logic [31:0] mem [RAM_DEPTH];

  logic [31:0] scratch_q, timer_q, compare_q;
  logic [31:0] scratch_d, timer_d, compare_d, rdata_d;
  logic [15:0] led_d;
  logic        irq_d;

  logic              is_mmio, is_rd, is_wr, ram_we;
  logic [15:0]       offset;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       mmio_rdata;

  // Replace the enabled bytes of old with the matching bytes of wd.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    merge_bytes = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merge_bytes[8*i +: 8] = wd[8*i +: 8];
    end
  endfunction

  // Decode, read mux and next-state for all MMIO registers.
  always_comb begin
    is_mmio    = (bus.data_sram_addr[31:16] == MMIO_HI);
    offset     = bus.data_sram_addr[15:0];
    ram_idx    = bus.data_sram_addr[RAM_AW+1:2];
    is_rd      = bus.data_sram_en && (bus.data_sram_wen == 4'h0);
    is_wr      = bus.data_sram_en && (bus.data_sram_wen != 4'h0);
    ram_we     = is_wr && !is_mmio;

    mmio_rdata = 32'h0;
    case (offset)
      OFF_LED:     mmio_rdata = {16'h0, led_out};
      OFF_SWITCH:  mmio_rdata = {16'h0, switch_in};
      OFF_SCRATCH: mmio_rdata = scratch_q;
      OFF_TIMER:   mmio_rdata = timer_q;
      OFF_COMPARE: mmio_rdata = compare_q;
      default:     mmio_rdata = 32'h0;
    endcase

    rdata_d   = bus.data_sram_rdata;
    led_d     = led_out;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'd1;
    compare_d = compare_q;
    // Match uses pre-update values; a COMPARE write overrides it below.
    irq_d     = timer_irq || (timer_q == compare_q);

    if (is_rd) rdata_d = is_mmio ? mmio_rdata : mem[ram_idx];

    if (is_wr && is_mmio) begin
      case (offset)
        OFF_LED: begin
          if (bus.data_sram_wen[0]) led_d[7:0]  = bus.data_sram_wdata[7:0];
          if (bus.data_sram_wen[1]) led_d[15:8] = bus.data_sram_wdata[15:8];
        end
        OFF_SCRATCH: scratch_d = merge_bytes(scratch_q, bus.data_sram_wdata, bus.data_sram_wen);
        OFF_TIMER:   timer_d   = merge_bytes(timer_q, bus.data_sram_wdata, bus.data_sram_wen);
        OFF_COMPARE: begin
          compare_d = merge_bytes(compare_q, bus.data_sram_wdata, bus.data_sram_wen);
          irq_d     = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Register state; RAM is deliberately outside reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_sram_rdata <= 32'h0;
      led_out             <= 16'h0;
      scratch_q           <= 32'h0;
      timer_q             <= 32'h0;
      compare_q           <= 32'hFFFF_FFFF;
      timer_irq           <= 1'b0;
    end else begin
      bus.data_sram_rdata <= rdata_d;
      led_out             <= led_d;
      scratch_q           <= scratch_d;
      timer_q             <= timer_d;
      compare_q           <= compare_d;
      timer_irq           <= irq_d;
    end
  end

  // Byte-enabled RAM write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && bus.data_sram_wen[i]) begin
        mem[ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder with a transaction-level model.
module tb_data_bus_responder;

  localparam int RAM_AW = 12;

  logic        clk;
  logic        rst;
  logic [15:0] switch_in;
  logic [15:0] led_out;
  logic        timer_irq;

  data_bus_responder_if bus();

  data_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .switch_in (switch_in),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Model state: timer is base value plus cycles elapsed since base was set.
  int          mcyc;
  int          m_tcyc;
  logic [31:0] m_tbase;
  logic [31:0] m_scratch;
  logic [31:0] m_compare;
  logic [15:0] m_led;
  logic [31:0] m_ram [int];
  logic [31:0] exp_rdata;
  logic        exp_irq;

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic int ram_key(input logic [31:0] addr);
    return int'((addr >> 2) & ((32'd1 << RAM_AW) - 32'd1));
  endfunction

  function automatic logic [31:0] m_timer();
    return m_tbase + 32'(mcyc - m_tcyc);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr, input logic [31:0] t);
    if (addr[31:16] != 16'hBFAF) return m_ram.exists(ram_key(addr)) ? m_ram[ram_key(addr)] : 32'h0;
    case (addr[15:0])
      16'hF000: return {16'h0, m_led};
      16'hF004: return {16'h0, switch_in};
      16'hF008: return m_scratch;
      16'hE000: return t;
      16'hE004: return m_compare;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    exp_rdata = 32'h0;
    exp_irq   = 1'b0;
    m_led     = 16'h0;
    m_scratch = 32'h0;
    m_compare = 32'hFFFF_FFFF;
    m_tbase   = 32'h0;
    m_tcyc    = mcyc;
  endtask

  // One bus cycle: update the model, present the access, step past the edge.
  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic [31:0] t;
    logic [31:0] tmp;
    logic        mmio;
    t    = m_timer();
    mmio = (addr[31:16] == 16'hBFAF);
    if (en && wen != 4'h0 && mmio && addr[15:0] == 16'hE004) exp_irq = 1'b0;
    else if (t == m_compare) exp_irq = 1'b1;
    if (en && wen == 4'h0) exp_rdata = m_read(addr, t);
    if (en && wen != 4'h0) begin
      if (!mmio) begin
        tmp = m_ram.exists(ram_key(addr)) ? m_ram[ram_key(addr)] : 32'h0;
        m_ram[ram_key(addr)] = m_merge(tmp, wdata, wen);
      end else begin
        case (addr[15:0])
          16'hF000: begin tmp = m_merge({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
          16'hF008: m_scratch = m_merge(m_scratch, wdata, wen);
          16'hE000: begin m_tbase = m_merge(t, wdata, wen); m_tcyc = mcyc + 1; end
          16'hE004: m_compare = m_merge(m_compare, wdata, wen);
          default: ;
        endcase
      end
    end
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    mcyc++;
  endtask

  task automatic do_reset();
    bus.data_sram_en  = 1'b0;
    bus.data_sram_wen = 4'h0;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata actual=%h expected=%h", bus.data_sram_rdata, 32'h0); end
    n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL reset_led actual=%h expected=%h", led_out, 16'h0); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq actual=%b expected=0", timer_irq); end
    drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_timer actual=%h expected=%h", bus.data_sram_rdata, 32'h0); end
    drive(1'b1, 4'h0, 32'hBFAF_E004, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_compare actual=%h expected=%h", bus.data_sram_rdata, 32'hFFFF_FFFF); end
    drive(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_scratch actual=%h expected=%h", bus.data_sram_rdata, 32'h0); end
  endtask

  task automatic test_ram();
    drive(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
    drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_full actual=%h expected=%h", bus.data_sram_rdata, 32'h1234_5678); end
    drive(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
    drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h12BB_56DD) begin n_fail++; $display("FAIL ram_partial actual=%h expected=%h", bus.data_sram_rdata, 32'h12BB_56DD); end
    // Upper address bits alias onto the same word; low two bits are ignored.
    drive(1'b1, 4'h0, 32'h7000_4013, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h12BB_56DD) begin n_fail++; $display("FAIL ram_alias actual=%h expected=%h", bus.data_sram_rdata, 32'h12BB_56DD); end
  endtask

  task automatic test_mmio();
    switch_in = 16'h3C3C;
    drive(1'b1, 4'hF, 32'hBFAF_F000, 32'hFFFF_00A5);
    n_checks++; if (led_out !== 16'h00A5) begin n_fail++; $display("FAIL mmio_led actual=%h expected=%h", led_out, 16'h00A5); end
    drive(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL mmio_led_rd actual=%h expected=%h", bus.data_sram_rdata, 32'h0000_00A5); end
    drive(1'b1, 4'h0, 32'hBFAF_F004, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0000_3C3C) begin n_fail++; $display("FAIL mmio_switch actual=%h expected=%h", bus.data_sram_rdata, 32'h0000_3C3C); end
    // Idle and write cycles must hold the last read data.
    drive(1'b0, 4'h0, 32'hBFAF_F008, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0000_3C3C) begin n_fail++; $display("FAIL hold_idle actual=%h expected=%h", bus.data_sram_rdata, 32'h0000_3C3C); end
    drive(1'b1, 4'b0011, 32'hBFAF_F008, 32'hDEAD_BEEF);
    n_checks++; if (bus.data_sram_rdata !== 32'h0000_3C3C) begin n_fail++; $display("FAIL hold_write actual=%h expected=%h", bus.data_sram_rdata, 32'h0000_3C3C); end
    drive(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL mmio_scratch actual=%h expected=%h", bus.data_sram_rdata, 32'h0000_BEEF); end
    drive(1'b1, 4'hF, 32'hBFAF_1234, 32'h5555_5555);
    drive(1'b1, 4'h0, 32'hBFAF_1234, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL mmio_unmapped actual=%h expected=%h", bus.data_sram_rdata, 32'h0); end
  endtask

  task automatic test_timer();
    drive(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
    drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL timer_write actual=%h expected=%h", bus.data_sram_rdata, 32'hFFFF_FFFE); end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL timer_wrap actual=%h expected=%h", bus.data_sram_rdata, 32'h0); end
    n_checks++; if (bus.data_sram_rdata !== exp_rdata) begin n_fail++; $display("FAIL timer_model actual=%h expected=%h", bus.data_sram_rdata, exp_rdata); end
  endtask

  task automatic test_irq();
    do_reset();
    drive(1'b1, 4'hF, 32'hBFAF_E004, 32'h0000_0010);
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early cycle=%0d actual=%b expected=0", k, timer_irq); end
    end
    for (int k = 16; k <= 19; k++) begin
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set cycle=%0d actual=%b expected=1", k, timer_irq); end
    end
    drive(1'b1, 4'h1, 32'hBFAF_E004, 32'h0000_0000);
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear actual=%b expected=0", timer_irq); end
    // Timer is 21 now; arm compare at 24 then rewrite it in the matching cycle.
    drive(1'b1, 4'hF, 32'hBFAF_E004, 32'd24);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_armed actual=%b expected=0", timer_irq); end
    drive(1'b1, 4'hF, 32'hBFAF_E004, 32'h0000_0100);
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_same_cycle actual=%b expected=0", timer_irq); end
    n_checks++; if (timer_irq !== exp_irq) begin n_fail++; $display("FAIL irq_model actual=%b expected=%b", timer_irq, exp_irq); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) drive(1'b1, 4'hF, 32'h0000_0100 + 32'(4*i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, 32'h0000_0100 + 32'(4*i), 32'h0);
      n_checks++; if (bus.data_sram_rdata !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL b2b_read idx=%0d actual=%h expected=%h", i, bus.data_sram_rdata, 32'hA000_0000 + 32'(i)); end
    end
    drive(1'b1, 4'hF, 32'h0000_0200, 32'h0BAD_CAFE);
    drive(1'b1, 4'h0, 32'h0000_0200, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL raw_next actual=%h expected=%h", bus.data_sram_rdata, 32'h0BAD_CAFE); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 4'hF, 32'hBFAF_F000, 32'h0000_5A5A);
    drive(1'b1, 4'hF, 32'hBFAF_E004, 32'd3);
    drive(1'b1, 4'hF, 32'hBFAF_F008, 32'hCAFE_F00D);
    drive(1'b1, 4'h0, 32'hBFAF_F008, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'hCAFE_F00D || timer_irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset rdata=%h irq=%b expected=%h/1", bus.data_sram_rdata, timer_irq, 32'hCAFE_F00D); end
    // Present a read, then pull reset mid-cycle before its edge.
    bus.data_sram_en   = 1'b1;
    bus.data_sram_wen  = 4'h0;
    bus.data_sram_addr = 32'h0000_0010;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL async_rdata actual=%h expected=%h", bus.data_sram_rdata, 32'h0); end
    n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL async_led actual=%h expected=%h", led_out, 16'h0); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL async_irq actual=%b expected=0", timer_irq); end
    bus.data_sram_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL async_timer actual=%h expected=%h", bus.data_sram_rdata, 32'h0); end
    drive(1'b1, 4'h0, 32'hBFAF_E004, 32'h0);
    n_checks++; if (bus.data_sram_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL async_compare actual=%h expected=%h", bus.data_sram_rdata, 32'hFFFF_FFFF); end
  endtask

  task automatic test_random();
    logic [31:0] pool [10];
    logic [31:0] addr, wdata;
    logic [3:0]  wen;
    logic        en;
    pool = '{32'h0000_0020, 32'h0000_0024, 32'h1000_0020, 32'h0000_3FFC, 32'hBFAF_F000,
             32'hBFAF_F004, 32'hBFAF_F008, 32'hBFAF_E004, 32'hBFAF_E000, 32'hBFAF_0010};
    for (int i = 0; i < 400; i++) begin
      addr      = pool[$urandom_range(0, 9)];
      en        = ($urandom_range(0, 7) != 0);
      wen       = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wdata     = $urandom;
      switch_in = 16'($urandom);
      if (addr == 32'hBFAF_E004) wdata = m_timer() + 32'($urandom_range(0, 6));
      if (addr == 32'hBFAF_E000 && $urandom_range(0, 3) != 0) wen = 4'h0;
      if (addr[31:16] != 16'hBFAF && !m_ram.exists(ram_key(addr))) wen = 4'hF;
      drive(en, wen, addr, wdata);
      n_checks++; if (bus.data_sram_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata iter=%0d actual=%h expected=%h", i, bus.data_sram_rdata, exp_rdata); end
      n_checks++; if (led_out !== m_led) begin n_fail++; $display("FAIL rand_led iter=%0d actual=%h expected=%h", i, led_out, m_led); end
      n_checks++; if (timer_irq !== exp_irq) begin n_fail++; $display("FAIL rand_irq iter=%0d actual=%b expected=%b", i, timer_irq, exp_irq); end
    end
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    mcyc                = 0;
    rst                 = 1'b0;
    switch_in           = 16'h0;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
    model_reset();
    test_reset();
    test_ram();
    test_mmio();
    test_timer();
    test_irq();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
